// File: rtl/uc_secuenciador.sv
// uc_secuenciador: control unit for the single-cycle CPU datapath.
// Decodes opcode[5:3] plus the zero flag into datapath controls, and adds a
// PC enable with a req/ack I/O handshake (timeout-protected) and a HALT state.
//
// Handshake: io_req is registered and rises the cycle after an IN/OUT is
// decoded; io_we qualifies it while io_req=1. The peripheral answers with
// io_ack, sampled on the rising clock in IO_WAIT; the access completes on the
// edge where io_ack=1, after which io_req drops. If no ack arrives within
// IO_TIMEOUT wait cycles the access is abandoned, the instruction is skipped
// and io_err latches high until reset. Ack and timeout on the same edge
// counts as a normal completion.
module uc_secuenciador #(
    parameter int IO_TIMEOUT = 255,
    parameter int TW         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       io_ack,
    output logic       s_inc,
    output logic       s_mux_alu,
    output logic       s_mux_datos,
    output logic       we3,
    output logic       wez,
    output logic [2:0] op_alu,
    output logic       pc_en,
    output logic       io_req,
    output logic       io_we,
    output logic       io_err,
    output logic       halted,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_IO_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(IO_TIMEOUT - 1);

    state_t        r_state;
    logic [TW-1:0] r_cnt;
    logic          r_io_req;
    logic          r_io_we;
    logic          r_io_err;
    logic          r_halted;

    logic          w_timeout;
    logic [2:0]    w_group;

    assign w_group   = opcode[5:3];
    assign w_timeout = (r_cnt == CNT_LAST);

    // Sequencer FSM: RUN / IO_WAIT / HALT plus the registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_io_req <= 1'b0;
            r_io_we  <= 1'b0;
            r_io_err <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    case (w_group)
                        3'b010, 3'b011: begin
                            r_state  <= ST_IO_WAIT;
                            r_io_req <= 1'b1;
                            r_io_we  <= w_group[0];
                            r_cnt    <= '0;
                        end
                        3'b111: begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_IO_WAIT: begin
                    if (io_ack) begin
                        r_state  <= ST_RUN;
                        r_io_req <= 1'b0;
                        r_cnt    <= '0;
                    end else if (w_timeout) begin
                        r_state  <= ST_RUN;
                        r_io_req <= 1'b0;
                        r_io_err <= 1'b1;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HALT: begin
                    // Only reset leaves HALT.
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Datapath control decode from state, opcode, z and io_ack.
    always_comb begin
        pc_en       = 1'b0;
        s_inc       = 1'b1;
        s_mux_alu   = 1'b0;
        s_mux_datos = 1'b0;
        we3         = 1'b0;
        wez         = 1'b0;
        op_alu      = 3'b000;
        if (reset) begin
            s_mux_alu   = 1'b1;
            s_mux_datos = 1'b1;
            op_alu      = opcode[2:0];
            case (r_state)
                ST_RUN: begin
                    pc_en = 1'b1;
                    case (w_group)
                        3'b000: begin
                            we3 = 1'b1;
                            wez = 1'b1;
                        end
                        3'b001: begin
                            we3       = 1'b1;
                            wez       = 1'b1;
                            s_mux_alu = 1'b0;
                        end
                        3'b010, 3'b011, 3'b111: begin
                            pc_en = 1'b0;
                        end
                        3'b100: begin
                            case (opcode[2:0])
                                3'b000:  s_inc = 1'b0;
                                3'b001:  s_inc = ~z;
                                3'b010:  s_inc = z;
                                default: s_inc = 1'b1;
                            endcase
                        end
                        default: begin
                        end
                    endcase
                end
                ST_IO_WAIT: begin
                    if (io_ack) begin
                        pc_en = 1'b1;
                        if (!r_io_we) begin
                            // IN completes by writing the Datos bus into the register file.
                            we3         = 1'b1;
                            s_mux_datos = 1'b0;
                        end
                    end else if (w_timeout) begin
                        // Abandon: advance past the instruction without writing.
                        pc_en = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_req      = r_io_req;
    assign io_we       = r_io_we;
    assign io_err      = r_io_err;
    assign halted      = r_halted;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uc_secuenciador.sv
// Testbench for uc_secuenciador: directed per-cycle vectors, expected control
// word queued by the driver, popped and compared by an independent monitor.
module tb_uc_secuenciador;

  localparam int IO_TIMEOUT = 4;

  // control word: pc_en s_inc s_mux_alu s_mux_datos we3 wez op_alu[2:0] io_req io_we io_err halted
  localparam logic [12:0] M_ALL  = 13'h1FFF;
  localparam logic [12:0] M_RUN  = 13'h1FFB;
  localparam logic [12:0] M_IO   = 13'h198F;
  localparam logic [12:0] M_IOIN = 13'h1B8F;
  localparam logic [12:0] M_HALT = 13'h118B;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic       io_ack;
  logic       s_inc, s_mux_alu, s_mux_datos, we3, wez, pc_en;
  logic [2:0] op_alu;
  logic       io_req, io_we, io_err, halted;
  logic [1:0] dbg_state;

  logic [12:0] exp_q[$];
  logic [12:0] mask_q[$];
  string       name_q[$];

  int n_checks;
  int n_fail;

  uc_secuenciador #(.IO_TIMEOUT(IO_TIMEOUT), .TW(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .io_ack(io_ack),
    .s_inc(s_inc), .s_mux_alu(s_mux_alu), .s_mux_datos(s_mux_datos),
    .we3(we3), .wez(wez), .op_alu(op_alu), .pc_en(pc_en),
    .io_req(io_req), .io_we(io_we), .io_err(io_err), .halted(halted),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [12:0] e(input logic pc, input logic si, input logic ma,
                                    input logic md, input logic w3, input logic wz,
                                    input logic [2:0] op, input logic rq, input logic iw,
                                    input logic er, input logic h);
    return {pc, si, ma, md, w3, wz, op, rq, iw, er, h};
  endfunction

  // driver: apply one cycle of inputs after the falling edge, queue the expected word
  task automatic step(input string nm, input logic rst, input logic [5:0] opc,
                      input logic zz, input logic ack, input logic [12:0] ex,
                      input logic [12:0] mk);
    @(negedge clk);
    #1;
    reset  = rst;
    opcode = opc;
    z      = zz;
    io_ack = ack;
    exp_q.push_back(ex);
    mask_q.push_back(mk);
    name_q.push_back(nm);
  endtask

  // monitor / scoreboard: sample mid low-phase, compare against queued expectation
  initial begin
    logic [12:0] act, ex, mk;
    string nm;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        mk = mask_q.pop_front();
        nm = name_q.pop_front();
        act = {pc_en, s_inc, s_mux_alu, s_mux_datos, we3, wez, op_alu,
               io_req, io_we, io_err, halted};
        n_checks++;
        if (((act ^ ex) & mk) != 13'h0) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b (mask %b)", nm, act, ex, mk);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [12:0] rst_w;
    n_checks = 0;
    n_fail   = 0;
    reset  = 1'b0;
    opcode = 6'b000000;
    z      = 1'b0;
    io_ack = 1'b0;
    rst_w  = e(0,1,0,0,0,0,3'b000,0,0,0,0);

    step("reset", 0, 6'b000010, 0, 0, rst_w, M_ALL);

    // T1: ALU ops, ack outside IO_WAIT ignored
    step("t1_alu_rr", 1, 6'b000010, 0, 0, e(1,1,1,1,1,1,3'b010,0,0,0,0), M_RUN);
    step("t1_alu_imm", 1, 6'b001101, 0, 1, e(1,1,0,1,1,1,3'b101,0,0,0,0), M_RUN);

    // T2: jumps and NOPs
    step("t2_jz_z1", 1, 6'b100001, 1, 0, e(1,0,1,1,0,0,3'b001,0,0,0,0), M_RUN);
    step("t2_jz_z0", 1, 6'b100001, 0, 0, e(1,1,1,1,0,0,3'b001,0,0,0,0), M_RUN);
    step("t2_jnz_z1", 1, 6'b100010, 1, 0, e(1,1,1,1,0,0,3'b010,0,0,0,0), M_RUN);
    step("t2_jnz_z0", 1, 6'b100010, 0, 0, e(1,0,1,1,0,0,3'b010,0,0,0,0), M_RUN);
    step("t2_j", 1, 6'b100000, 1, 0, e(1,0,1,1,0,0,3'b000,0,0,0,0), M_RUN);
    step("t2_jnop", 1, 6'b100111, 0, 0, e(1,1,1,1,0,0,3'b111,0,0,0,0), M_RUN);
    step("t2_nop101", 1, 6'b101011, 0, 0, e(1,1,1,1,0,0,3'b011,0,0,0,0), M_RUN);

    // T3: IN with ack on the third wait cycle
    step("t3_in_dec", 1, 6'b010000, 0, 0, e(0,1,1,1,0,0,3'b000,0,0,0,0), M_RUN);
    step("t3_wait1", 1, 6'b010000, 0, 0, e(0,1,0,0,0,0,3'b000,1,0,0,0), M_IO);
    step("t3_wait2", 1, 6'b010000, 0, 0, e(0,1,0,0,0,0,3'b000,1,0,0,0), M_IO);
    step("t3_ack", 1, 6'b010000, 0, 1, e(1,1,0,0,1,0,3'b000,1,0,0,0), M_IOIN);
    step("t3_after", 1, 6'b000001, 0, 0, e(1,1,1,1,1,1,3'b001,0,0,0,0), M_RUN);

    // T4: OUT timeout, sticky io_err
    step("t4_out_dec", 1, 6'b011000, 0, 0, e(0,1,1,1,0,0,3'b000,0,0,0,0), M_RUN);
    step("t4_wait0", 1, 6'b011000, 0, 0, e(0,1,0,0,0,0,3'b000,1,1,0,0), M_IO);
    step("t4_wait1", 1, 6'b011000, 0, 0, e(0,1,0,0,0,0,3'b000,1,1,0,0), M_IO);
    step("t4_wait2", 1, 6'b011000, 0, 0, e(0,1,0,0,0,0,3'b000,1,1,0,0), M_IO);
    step("t4_abandon", 1, 6'b011000, 0, 0, e(1,1,0,0,0,0,3'b000,1,1,0,0), M_IO);
    step("t4_err_alu", 1, 6'b000011, 0, 0, e(1,1,1,1,1,1,3'b011,0,0,1,0), M_RUN);
    step("t4_err_j", 1, 6'b100000, 0, 0, e(1,0,1,1,0,0,3'b000,0,0,1,0), M_RUN);

    // T6a: async reset in the middle of IO_WAIT
    step("t6_in_dec", 1, 6'b010000, 0, 0, e(0,1,1,1,0,0,3'b000,0,0,1,0), M_RUN);
    step("t6_wait", 1, 6'b010000, 0, 0, e(0,1,0,0,0,0,3'b000,1,0,1,0), M_IO);
    step("t6_async_rst", 0, 6'b010000, 0, 1, rst_w, M_ALL);
    step("t6_post_rst", 1, 6'b000000, 0, 0, e(1,1,1,1,1,1,3'b000,0,0,0,0), M_RUN);

    // T6b: ack on the timeout edge is a normal completion
    step("t6_out_dec", 1, 6'b011000, 0, 0, e(0,1,1,1,0,0,3'b000,0,0,0,0), M_RUN);
    step("t6_w0", 1, 6'b011000, 0, 0, e(0,1,0,0,0,0,3'b000,1,1,0,0), M_IO);
    step("t6_w1", 1, 6'b011000, 0, 0, e(0,1,0,0,0,0,3'b000,1,1,0,0), M_IO);
    step("t6_w2", 1, 6'b011000, 0, 0, e(0,1,0,0,0,0,3'b000,1,1,0,0), M_IO);
    step("t6_ack_tmo", 1, 6'b011000, 0, 1, e(1,1,0,0,0,0,3'b000,1,1,0,0), M_IO);
    step("t6_no_err", 1, 6'b000000, 0, 0, e(1,1,1,1,1,1,3'b000,0,0,0,0), M_RUN);

    // T5: HALT until reset
    step("t5_halt_dec", 1, 6'b111000, 0, 0, e(0,1,0,0,0,0,3'b000,0,0,0,0), M_HALT);
    step("t5_halt_alu", 1, 6'b000010, 0, 0, e(0,1,0,0,0,0,3'b000,0,0,0,1), M_HALT);
    step("t5_halt_in", 1, 6'b010000, 0, 1, e(0,1,0,0,0,0,3'b000,0,0,0,1), M_HALT);
    step("t5_halt_j", 1, 6'b100000, 1, 0, e(0,1,0,0,0,0,3'b000,0,0,0,1), M_HALT);
    step("t5_rst", 0, 6'b100000, 0, 0, rst_w, M_ALL);
    step("t5_resume", 1, 6'b000010, 0, 0, e(1,1,1,1,1,1,3'b010,0,0,0,0), M_RUN);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
